// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: takes register-level commands, drives an external
// combinational ALU from a 4-entry register file, writes the result back
// and returns it over a valid/ready response channel.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | operands on the ALU, result captured at the end of this cycle
// RESP  | response presented, held until rsp_ready
module alu_cmd_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ld,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_rs1,
  input  logic [1:0]       cmd_rs2,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_z_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_c,
  output logic             rsp_z,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] regs [4];
  logic [1:0]       rd_q;
  logic             cmd_accept;
  logic             rsp_done;

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign rsp_done   = rsp_valid && rsp_ready;
  assign dbg_data   = regs[dbg_sel];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; loads skip ISSUE because the ALU is not involved.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          state_d = cmd_ld ? RESP : ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        if (rsp_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU operand/opcode latches; sources are sampled at accept so a
  // destination that aliases a source still feeds the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 3'b000;
      rd_q       <= 2'd0;
    end else if (cmd_accept && !cmd_ld) begin
      alu_a      <= regs[cmd_rs1];
      alu_b      <= regs[cmd_rs2];
      alu_opcode <= cmd_op;
      rd_q       <= cmd_rd;
    end
  end

  // Register file writes: immediate on load accept, ALU result at end of ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (cmd_accept && cmd_ld) begin
      regs[cmd_rd] <= cmd_imm;
    end else if (state_q == ISSUE) begin
      regs[rd_q] <= alu_out;
    end
  end

  // Response payload, captured alongside the register write and held in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_c    <= 1'b0;
      rsp_z    <= 1'b0;
    end else if (cmd_accept && cmd_ld) begin
      rsp_data <= cmd_imm;
      rsp_c    <= 1'b0;
      rsp_z    <= (cmd_imm == '0);
    end else if (state_q == ISSUE) begin
      rsp_data <= alu_out;
      rsp_c    <= alu_cout;
      rsp_z    <= alu_z_flag;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer; includes a behavioural model of the
// 8-bit combinational ALU that the sequencer drives.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_ld;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_out;
  logic       alu_cout;
  logic       alu_z_flag;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_c, rsp_z;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ld     (cmd_ld),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm    (cmd_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_z_flag (alu_z_flag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_c      (rsp_c),
    .rsp_z      (rsp_z),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  // Combinational ALU model; subtract carry is 1 when there is no borrow.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'd0;
    case (alu_opcode)
      3'b000: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      3'b010: alu_sum = {1'b0, alu_a & alu_b};
      3'b011: alu_sum = {1'b0, alu_a | alu_b};
      3'b100: alu_sum = {1'b0, alu_a ^ alu_b};
      3'b101: alu_sum = {8'd0, alu_a > alu_b};
      3'b110: alu_sum = {alu_a, 1'b0};
      default: alu_sum = {alu_b, 1'b0};
    endcase
    alu_out    = alu_sum[7:0];
    alu_cout   = alu_sum[8];
    alu_z_flag = (alu_sum[7:0] == 8'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input logic [1:0] idx, input logic [7:0] exp, input string tag);
    dbg_sel = idx;
    #1;
    chk(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic drive_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
    cmd_ld    = ld;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
  endtask

  // Called at a negedge with a command driven; returns at the negedge after the accept edge.
  task automatic accept_cmd(input string tag);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept_bound"}, {31'd0, (n < 20)}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                         input logic [7:0] exp_data, input logic exp_c, input logic exp_z,
                         input string tag);
    int lat = 1;
    drive_cmd(ld, op, rd, rs1, rs2, imm);
    accept_cmd(tag);
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, ld ? 32'd1 : 32'd2);
    chk({tag, "_data"}, {24'd0, rsp_data}, {24'd0, exp_data});
    chk({tag, "_c"}, {31'd0, rsp_c}, {31'd0, exp_c});
    chk({tag, "_z"}, {31'd0, rsp_z}, {31'd0, exp_z});
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_after"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_ld    = 1'b0;
    cmd_op    = 3'b000;
    cmd_rd    = 2'd0;
    cmd_rs1   = 2'd0;
    cmd_rs2   = 2'd0;
    cmd_imm   = 8'd0;
    rsp_ready = 1'b1;
    dbg_sel   = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk_reg(2'd0, 8'h00, "rst_r0");
    chk_reg(2'd1, 8'h00, "rst_r1");
    chk_reg(2'd2, 8'h00, "rst_r2");
    chk_reg(2'd3, 8'h00, "rst_r3");
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_alu_opcode", {29'd0, alu_opcode}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    @(negedge clk);

    // Loads and basic ALU ops
    run_cmd(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 1'b0, "ld_r1");
    run_cmd(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 8'h03, 8'h03, 1'b0, 1'b0, "ld_r2");
    run_cmd(1'b0, 3'b000, 2'd3, 2'd1, 2'd2, 8'h00, 8'h08, 1'b0, 1'b0, "add_r3");
    chk_reg(2'd3, 8'h08, "add_r3_reg");
    chk("add_alu_a", {24'd0, alu_a}, 32'h05);
    chk("add_alu_b", {24'd0, alu_b}, 32'h03);
    run_cmd(1'b0, 3'b001, 2'd0, 2'd2, 2'd1, 8'h00, 8'hFE, 1'b0, 1'b0, "sub_borrow");
    chk_reg(2'd0, 8'hFE, "sub_r0_reg");
    run_cmd(1'b0, 3'b001, 2'd3, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1, "sub_self");
    chk_reg(2'd3, 8'h00, "sub_r3_reg");
    run_cmd(1'b0, 3'b110, 2'd3, 2'd1, 2'd0, 8'h00, 8'h0A, 1'b0, 1'b0, "shl_a");
    run_cmd(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, "ld_zero");

    // Destination aliases a source: ALU sees the old value
    run_cmd(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, "ld_r1_ff");
    run_cmd(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0, "ld_r2_01");
    run_cmd(1'b0, 3'b000, 2'd1, 2'd1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b1, "add_wrap");
    chk("add_wrap_alu_a", {24'd0, alu_a}, 32'hFF);
    chk_reg(2'd1, 8'h00, "add_wrap_r1_reg");

    // Backpressure: r0 = r2 + r2 = 0x02, response stalled
    rsp_ready = 1'b0;
    drive_cmd(1'b0, 3'b000, 2'd0, 2'd2, 2'd2, 8'h00);
    accept_cmd("bp_add");
    @(negedge clk);
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    drive_cmd(1'b0, 3'b100, 2'd3, 2'd2, 2'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_data", {24'd0, rsp_data}, 32'h02);
      chk("bp_hold_cz", {30'd0, rsp_c, rsp_z}, 32'd0);
      chk("bp_hold_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    chk_reg(2'd0, 8'h02, "bp_r0_reg");
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_second_accepted", {31'd0, cmd_ready}, 32'd0);
    chk("bp_second_opcode", {29'd0, alu_opcode}, 32'd4);
    chk("bp_second_alu_a", {24'd0, alu_a}, 32'h01);
    chk("bp_second_alu_b", {24'd0, alu_b}, 32'h02);
    @(negedge clk);
    chk("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_second_data", {24'd0, rsp_data}, 32'h03);
    @(posedge clk);
    @(negedge clk);

    // Reset during ISSUE of ADD rd=2 (r1 + r0 = 0x00 + 0x02)
    drive_cmd(1'b0, 3'b000, 2'd2, 2'd1, 2'd0, 8'h00);
    accept_cmd("rst_issue");
    chk("rst_issue_in_issue", {31'd0, cmd_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_issue_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_issue_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_issue_alu_a", {24'd0, alu_a}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reg(2'd2, 8'h00, "rst_issue_r2");
    chk_reg(2'd0, 8'h00, "rst_issue_r0");
    chk("rst_issue_valid_after", {31'd0, rsp_valid}, 32'd0);
    chk("rst_issue_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("rst_issue_rsp_data", {24'd0, rsp_data}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
